// File: rtl/msgdma_seq_pkg.sv
// Shared types and constants for the mSGDMA descriptor sequencer: control word,
// FSM states and the 128-bit standard descriptor layout.
package msgdma_seq_pkg;

  localparam int CTRL_GO_BIT  = 31;
  localparam int CTRL_IRQ_BIT = 14;
  localparam int CTRL_EOP_BIT = 9;
  localparam int CTRL_SOP_BIT = 8;

  // Evaluates to 32'h8000_4300.
  localparam logic [31:0] DESC_CTRL = (32'd1 << CTRL_GO_BIT)  | (32'd1 << CTRL_IRQ_BIT) |
                                      (32'd1 << CTRL_EOP_BIT) | (32'd1 << CTRL_SOP_BIT);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  // Packed MSB first: ctrl occupies [127:96], addr occupies [31:0].
  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] len;
    logic [31:0] rsvd;
    logic [31:0] addr;
  } desc_t;

  function automatic desc_t make_desc(input logic [31:0] addr, input logic [31:0] len);
    desc_t d;
    d.ctrl = DESC_CTRL;
    d.len  = len;
    d.rsvd = '0;
    d.addr = addr;
    return d;
  endfunction

endpackage

// File: rtl/msgdma_desc_sequencer_if.sv
// Request, descriptor-slave and stream-tap signals of the descriptor sequencer.
// The master modport is the sequencer's view; slave is the surrounding fabric.
interface msgdma_desc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_len;
  logic              desc_write;
  logic [127:0]      desc_writedata;
  logic              desc_waitrequest;
  logic              st_valid;
  logic              st_ready;

  modport master (
    input  req_valid, req_addr, req_len, desc_waitrequest, st_valid, st_ready,
    output req_ready, desc_write, desc_writedata
  );

  modport slave (
    output req_valid, req_addr, req_len, desc_waitrequest, st_valid, st_ready,
    input  req_ready, desc_write, desc_writedata
  );
endinterface

// File: rtl/msgdma_len_fifo.sv
// Show-ahead synchronous FIFO holding the beat count of each issued descriptor.
// The head is valid whenever the FIFO is not empty; push+pop while full is legal.
module msgdma_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/msgdma_desc_sequencer.sv
// Turns transfer requests into mSGDMA standard descriptor writes and tracks
// completion by counting beats on the tapped MM-to-ST stream.
module msgdma_desc_sequencer
  import msgdma_seq_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_BYTES      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  msgdma_desc_sequencer_if.master            bus,
  output logic                               busy,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               done_pulse,
  output logic [CNT_W-1:0]                   done_count,
  output logic                               err_bad_len,
  output logic                               err_stray_beat
);
  localparam int          SHIFT    = $clog2(DATA_BYTES);
  localparam int          LEN_W    = 32 - SHIFT;
  localparam int          OUT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [31:0] LEN_MASK = 32'(DATA_BYTES - 1);

  state_t            state, state_nxt;
  desc_t             desc_q;
  logic              req_ready_q, req_ready_nxt, desc_write_q;
  logic              accept, reject, issue_done;
  logic              len_ok, beat, pop, stray;
  logic [OUT_W-1:0]  outstanding_nxt;
  logic [LEN_W-1:0]  beat_cnt, fifo_head;
  logic              fifo_empty;
  logic [ADDR_W-1:0] addr_in;

  assign addr_in            = bus.req_addr;
  assign bus.req_ready      = req_ready_q;
  assign bus.desc_write     = desc_write_q;
  assign bus.desc_writedata = desc_q;

  assign len_ok = (bus.req_len != 32'd0) && ((bus.req_len & LEN_MASK) == 32'd0);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    reject     = 1'b0;
    issue_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          if (len_ok) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!bus.desc_waitrequest) begin
          issue_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A beat completes the head descriptor when it is the last one that descriptor expects.
  assign beat  = bus.st_valid && bus.st_ready;
  assign pop   = beat && !fifo_empty && (beat_cnt == fifo_head - 1'b1);
  assign stray = beat && fifo_empty;

  always_comb begin
    outstanding_nxt = outstanding;
    if (issue_done && !pop)      outstanding_nxt = outstanding + 1'b1;
    else if (pop && !issue_done) outstanding_nxt = outstanding - 1'b1;
  end

  // Ready is registered from next-state values so it drops right after an acceptance.
  assign req_ready_nxt = (state_nxt == IDLE) && (outstanding_nxt < OUT_W'(MAX_OUTSTANDING));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_q    <= 1'b0;
      desc_write_q   <= 1'b0;
      desc_q         <= '0;
      outstanding    <= '0;
      beat_cnt       <= '0;
      done_pulse     <= 1'b0;
      done_count     <= '0;
      err_bad_len    <= 1'b0;
      err_stray_beat <= 1'b0;
    end else begin
      req_ready_q    <= req_ready_nxt;
      desc_write_q   <= (state_nxt == ISSUE);
      if (accept) desc_q <= make_desc(32'(addr_in), bus.req_len);
      outstanding    <= outstanding_nxt;
      if (pop)                     beat_cnt <= '0;
      else if (beat && !fifo_empty) beat_cnt <= beat_cnt + 1'b1;
      done_pulse     <= pop;
      if (pop) done_count <= done_count + 1'b1;
      err_bad_len    <= reject;
      err_stray_beat <= stray;
    end
  end

  assign busy = (state != IDLE) || (outstanding != '0);

  msgdma_len_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (issue_done),
    .push_data (desc_q.len[31:SHIFT]),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_msgdma_desc_sequencer.sv
// Scoreboard bench for msgdma_desc_sequencer: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_msgdma_desc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [2:0]  outstanding;
  logic        done_pulse;
  logic [15:0] done_count;
  logic        err_bad_len;
  logic        err_stray_beat;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [127:0] data;
    int           hold;
  } exp_desc_t;

  exp_desc_t   exp_desc_q[$];
  logic [15:0] exp_done_q[$];
  int          exp_bad_q[$];
  int          exp_stray_q[$];

  msgdma_desc_sequencer_if #(.ADDR_W(32)) bus ();

  msgdma_desc_sequencer #(
    .ADDR_W          (32),
    .DATA_BYTES      (4),
    .MAX_OUTSTANDING (4),
    .CNT_W           (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .busy           (busy),
    .outstanding    (outstanding),
    .done_pulse     (done_pulse),
    .done_count     (done_count),
    .err_bad_len    (err_bad_len),
    .err_stray_beat (err_stray_beat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT event against the scoreboard queues.
  int           hold_cnt = 0;
  logic [127:0] first_data;

  always @(negedge clk) begin
    if (reset) begin
      hold_cnt = 0;
    end else begin
      if (bus.desc_write) begin
        if (hold_cnt == 0) first_data = bus.desc_writedata;
        hold_cnt++;
        if (!bus.desc_waitrequest) begin
          check("desc_expected", 128'(exp_desc_q.size() != 0), 128'd1);
          if (exp_desc_q.size() != 0) begin
            exp_desc_t e;
            e = exp_desc_q.pop_front();
            check("desc_data_first", first_data, e.data);
            check("desc_data_final", bus.desc_writedata, e.data);
            check("desc_hold_cycles", 128'(hold_cnt), 128'(e.hold));
          end
          hold_cnt = 0;
        end
      end
      if (done_pulse) begin
        check("done_expected", 128'(exp_done_q.size() != 0), 128'd1);
        if (exp_done_q.size() != 0) check("done_count", done_count, exp_done_q.pop_front());
      end
      if (err_bad_len) begin
        check("bad_len_expected", 128'(exp_bad_q.size() != 0), 128'd1);
        if (exp_bad_q.size() != 0) void'(exp_bad_q.pop_front());
      end
      if (err_stray_beat) begin
        check("stray_expected", 128'(exp_stray_q.size() != 0), 128'd1);
        if (exp_stray_q.size() != 0) void'(exp_stray_q.pop_front());
      end
    end
  end

  task automatic send_req(input logic [31:0] addr, input logic [31:0] len,
                          input int waits, input bit good);
    int n = 0;
    exp_desc_t e;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    check("req_ready_wait", bus.req_ready, 1'b1);
    if (good) begin
      e.data = {32'h8000_4300, len, 32'h0, addr};
      e.hold = waits + 1;
      exp_desc_q.push_back(e);
    end else begin
      exp_bad_q.push_back(1);
    end
    bus.desc_waitrequest = (waits > 0);
    tick();
    bus.req_valid = 1'b0;
    if (good) begin
      check("desc_write_lat1", bus.desc_write, 1'b1);
      check("no_b2b_ready", bus.req_ready, 1'b0);
      repeat (waits) begin
        tick();
        check("desc_write_held", bus.desc_write, 1'b1);
      end
      bus.desc_waitrequest = 1'b0;
      tick();
      check("desc_write_drop", bus.desc_write, 1'b0);
    end else begin
      check("err_bad_len_pulse", err_bad_len, 1'b1);
      check("no_desc_write_bad", bus.desc_write, 1'b0);
    end
  endtask

  task automatic beats(input int n);
    bus.st_valid = 1'b1;
    bus.st_ready = 1'b1;
    repeat (n) tick();
    bus.st_valid = 1'b0;
    bus.st_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_desc_t e;
    reset                = 1'b1;
    bus.req_valid        = 1'b0;
    bus.req_addr         = '0;
    bus.req_len          = '0;
    bus.desc_waitrequest = 1'b0;
    bus.st_valid         = 1'b0;
    bus.st_ready         = 1'b0;
    tick();
    tick();
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_desc_write", bus.desc_write, 1'b0);
    check("rst_desc_data", bus.desc_writedata, 128'd0);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_done_pulse", done_pulse, 1'b0);
    check("rst_done_count", done_count, 16'd0);
    check("rst_err_bad_len", err_bad_len, 1'b0);
    check("rst_err_stray", err_stray_beat, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", bus.req_ready, 1'b1);

    // Basic 16-byte transfer, 4 beats with one unready stall in between.
    send_req(32'h2000_0000, 32'd16, 0, 1'b1);
    check("t1_outstanding", outstanding, 3'd1);
    check("t1_busy", busy, 1'b1);
    beats(2);
    bus.st_valid = 1'b1;
    tick();
    bus.st_valid = 1'b0;
    check("t1_no_early_done", done_pulse, 1'b0);
    exp_done_q.push_back(16'd1);
    beats(2);
    check("t1_done_pulse", done_pulse, 1'b1);
    check("t1_done_count", done_count, 16'd1);
    check("t1_outstanding_0", outstanding, 3'd0);
    tick();
    check("t1_done_one_cycle", done_pulse, 1'b0);
    check("t1_idle", busy, 1'b0);

    // Waitrequest held 5 cycles: write held 6 cycles, one FIFO push.
    send_req(32'h0000_1000, 32'd8, 5, 1'b1);
    check("t2_outstanding", outstanding, 3'd1);
    exp_done_q.push_back(16'd2);
    beats(2);
    check("t2_done", done_pulse, 1'b1);
    check("t2_outstanding_0", outstanding, 3'd0);

    // Fill to MAX_OUTSTANDING, then free a slot with two beats.
    send_req(32'h0000_0100, 32'd8, 0, 1'b1);
    send_req(32'h0000_0200, 32'd8, 0, 1'b1);
    send_req(32'h0000_0300, 32'd8, 0, 1'b1);
    send_req(32'h0000_0400, 32'd8, 0, 1'b1);
    check("t3_full_outstanding", outstanding, 3'd4);
    check("t3_full_not_ready", bus.req_ready, 1'b0);
    bus.req_addr  = 32'h0000_0500;
    bus.req_len   = 32'd4;
    bus.req_valid = 1'b1;
    exp_done_q.push_back(16'd3);
    beats(1);
    check("t3_still_full", bus.req_ready, 1'b0);
    beats(1);
    check("t3_done", done_pulse, 1'b1);
    check("t3_ready_after_done", bus.req_ready, 1'b1);
    check("t3_outstanding_3", outstanding, 3'd3);
    e.data = {32'h8000_4300, 32'd4, 32'h0, 32'h0000_0500};
    e.hold = 1;
    exp_desc_q.push_back(e);
    tick();
    bus.req_valid = 1'b0;
    check("t3_fifth_write", bus.desc_write, 1'b1);
    tick();
    check("t3_outstanding_4", outstanding, 3'd4);
    exp_done_q.push_back(16'd4);
    beats(2);
    exp_done_q.push_back(16'd5);
    beats(2);
    exp_done_q.push_back(16'd6);
    beats(2);
    exp_done_q.push_back(16'd7);
    beats(1);
    check("t3_single_beat_done", done_pulse, 1'b1);
    check("t3_drained", outstanding, 3'd0);

    // Rejected lengths, back to back.
    send_req(32'h0000_0000, 32'd0, 0, 1'b0);
    send_req(32'h0000_0000, 32'd6, 0, 1'b0);
    tick();
    check("t4_err_cleared", err_bad_len, 1'b0);
    check("t4_outstanding", outstanding, 3'd0);
    check("t4_no_write", bus.desc_write, 1'b0);

    // Final beat of A lands on the edge that accepts B's descriptor write.
    send_req(32'h0000_0600, 32'd8, 0, 1'b1);
    beats(1);
    bus.req_addr  = 32'h0000_0700;
    bus.req_len   = 32'd12;
    bus.req_valid = 1'b1;
    e.data = {32'h8000_4300, 32'd12, 32'h0, 32'h0000_0700};
    e.hold = 1;
    exp_desc_q.push_back(e);
    tick();
    bus.req_valid = 1'b0;
    bus.st_valid  = 1'b1;
    bus.st_ready  = 1'b1;
    exp_done_q.push_back(16'd8);
    tick();
    bus.st_valid = 1'b0;
    bus.st_ready = 1'b0;
    check("t5_outstanding_same", outstanding, 3'd1);
    check("t5_done", done_pulse, 1'b1);
    beats(2);
    check("t5_b_not_done", done_pulse, 1'b0);
    exp_done_q.push_back(16'd9);
    beats(1);
    check("t5_b_done", done_pulse, 1'b1);
    check("t5_outstanding_0", outstanding, 3'd0);

    // Reset while a write is stalled; FIFO must be flushed.
    send_req(32'h0000_0800, 32'd8, 0, 1'b1);
    bus.req_addr         = 32'h0000_0900;
    bus.req_len          = 32'd8;
    bus.req_valid        = 1'b1;
    bus.desc_waitrequest = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("t6_write_up", bus.desc_write, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    check("t6_write_dropped", bus.desc_write, 1'b0);
    check("t6_outstanding", outstanding, 3'd0);
    check("t6_done_count", done_count, 16'd0);
    reset                = 1'b0;
    bus.desc_waitrequest = 1'b0;
    tick();
    check("t6_ready", bus.req_ready, 1'b1);
    repeat (3) exp_stray_q.push_back(1);
    beats(3);
    check("t6_stray_pulse", err_stray_beat, 1'b1);
    tick();
    tick();
    check("t6_no_done", done_count, 16'd0);
    check("t6_idle", busy, 1'b0);

    check("sb_desc_drained", 128'(exp_desc_q.size()), 128'd0);
    check("sb_done_drained", 128'(exp_done_q.size()), 128'd0);
    check("sb_bad_drained", 128'(exp_bad_q.size()), 128'd0);
    check("sb_stray_drained", 128'(exp_stray_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
